fifo_rd_ctrl: RTL
=================

Name: fifo_rd_ctrl

Overview:
- Read-domain controller for the async FIFO. Runs entirely on rclk.
- Synchronises the write pointer and owns the Gray-coded read pointer and the empty flag.
- Drives ren/raddr into the dual-port FIFO memory, whose registered read data returns one cycle later.
- Presents data to the consumer as a first-word-fall-through valid/ready stream, buffered through a 2-entry output skid.

Parameters:
- D_WIDTH, 32: data width; matches the memory.
- A_WIDTH, 8: memory address width; depth = 2**A_WIDTH; pointers are A_WIDTH+1 bits.
- SYNC_STAGES, 2: flop stages on the wptr_gray synchroniser; legal range 2..4.

Ports:
- rclk  in  1  read-domain clock.
- rrst_n  in  1  asynchronous active-low reset.
- wptr_gray  in  A_WIDTH+1  write pointer, Gray code, from wclk domain (asynchronous).
- rptr_gray  out  A_WIDTH+1  read pointer, Gray code, registered; goes to write-domain full logic.
- ren  out  1  memory read enable.
- raddr  out  A_WIDTH  memory read address = rbin[A_WIDTH-1:0].
- rdata  in  D_WIDTH  memory read data, valid the cycle after ren.
- m_valid  out  1  output word available.
- m_ready  in  1  consumer accepts; transfer occurs when m_valid && m_ready.
- m_data  out  D_WIDTH  head of output skid.
- rempty  out  1  memory empty (synchronised view), registered.
- rlevel  out  A_WIDTH+1  unread words still in memory (synchronised view), registered.
- rerr  out  1  sticky protocol error (see Optional Feature).

Behaviour:
- Reset (async assert, sync release): all of the following are cleared.
  - rbin=0, rptr_gray=0, synchroniser flops=0, skid empty, in-flight flag=0.
  - rempty=1, rlevel=0, m_valid=0, m_data=0, ren=0, rerr=0.
- Reset mid-operation discards any in-flight read and all buffered words.
- Synchronisation: wptr_gray passes through SYNC_STAGES flops to give wq_gray, which is converted to binary wq_bin.
- Level and empty:
  - rlevel <= wq_bin - rbin_next, computed modulo 2**(A_WIDTH+1).
  - rempty <= (rgray_next == wq_gray).
- Read issue:
  - slots = skid_cnt + inflight, range 0..2.
  - ren = !rempty && (slots < 2 || pop), where pop = m_valid && m_ready.
  - On ren: rbin_next = rbin + 1, rptr_gray <= bin2gray(rbin_next), inflight <= 1 for the next cycle.
- Return: in the cycle after ren, rdata is written into the skid tail. This write is simultaneous with any pop: the skid pops the head and pushes the tail in the same cycle.
- m_valid = (skid_cnt != 0); m_data = skid head. Both are registered outputs.
- Throughput: 1 word/cycle is sustained while memory is non-empty and m_ready=1.
- Backpressure: with m_ready=0 at most 2 words leave memory; ren then stays low.
- Latency: a wptr_gray change stable before edge 0 produces m_valid high after edge SYNC_STAGES+2.
- Wrap: pointers wrap naturally at 2**(A_WIDTH+1). Full depth (rlevel = 2**A_WIDTH) is legal.
- m_data is held stable while m_valid && !m_ready.

Optional Feature:
- Macro: FIFO_RD_GRAY_CHECK_EN.
- Defined: rerr is set (sticky until reset) when either of these holds:
  - successive wq_gray values differ in more than 1 bit;
  - the computed rlevel exceeds 2**A_WIDTH.
- Undefined: checker logic is absent and rerr is tied 0.

Decomposition:
- Package fifo_pkg:
  - bin2gray and gray2bin functions, parameterised by width;
  - ptr_t typedef;
  - SKID_DEPTH=2 constant.
- Sub-module sync_ff: SYNC_STAGES-deep, W-bit flop chain clocked by rclk, reset by rrst_n. Used once, for wptr_gray.

Test Plan (A_WIDTH=3, D_WIDTH=8, SYNC_STAGES=2):
- Reset: hold rrst_n=0 with random wptr_gray -> rempty=1, m_valid=0, rptr_gray=0, rlevel=0, ren=0.
- Single word: memory[0]=0xA5, wptr_gray 0->1 -> m_valid high after 4 rclk edges, m_data=0xA5; pop -> rptr_gray=1, rempty=1.
- Streaming: 8 words 0x10..0x17, m_ready=1 throughout -> 8 consecutive transfers in order, 1 per cycle, no gap after the first.
- Backpressure: 8 words written, m_ready=0 for 10 cycles -> exactly 2 ren pulses, rlevel=6, m_data=0x10 stable; release -> remaining 0x11..0x17 in order.
- Wrap: 20 words through a depth-8 FIFO -> rptr_gray sequence follows Gray code 0..15 then 0; data in order; rlevel=8 reported when full.
- Reset mid-stream: assert rrst_n low with skid holding 2 words and ren active -> all outputs at reset values the same cycle; nothing emitted after release until wptr_gray changes.
- With FIFO_RD_GRAY_CHECK_EN defined: force wptr_gray 0->3 -> rerr=1 after synchroniser delay and stays set.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared pointer type, Gray-code helpers and skid depth for the async FIFO.
// The helpers are width-agnostic: zero-extend into ptr_t, convert, then truncate back.
package fifo_pkg;
  localparam int PTR_W = 32;
  localparam int SKID_DEPTH = 2;
  typedef logic [PTR_W-1:0] ptr_t;
  function automatic ptr_t bin2gray(ptr_t b);
    return b ^ (b >> 1);
  endfunction
  function automatic ptr_t gray2bin(ptr_t g);
    ptr_t b;
    for (int i = 0; i < PTR_W; i++) b[i] = ^(g >> i);
    return b;
  endfunction
endpackage

// File: rtl/fifo_rd_ctrl_sync_ff.sv
// sync_ff: STAGES-deep, W-bit flop chain bringing an asynchronous bus into rclk.
module sync_ff #(
  parameter int W = 1,
  parameter int STAGES = 2
) (
  input  logic         rclk,
  input  logic         rrst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [STAGES-1:0][W-1:0] chain;
  always_ff @(posedge rclk or negedge rrst_n)
    if (!rrst_n) chain <= '0;
    else chain <= {chain[STAGES-2:0], d};
  assign q = chain[STAGES-1];
endmodule

// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: async FIFO read side with FWFT 2-entry output skid.
// Optional macro FIFO_RD_GRAY_CHECK_EN enables the sticky rerr protocol checker.
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int D_WIDTH = 32,
  parameter int A_WIDTH = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               rclk,
  input  logic               rrst_n,
  input  logic [A_WIDTH:0]   wptr_gray,
  output logic [A_WIDTH:0]   rptr_gray,
  output logic               ren,
  output logic [A_WIDTH-1:0] raddr,
  input  logic [D_WIDTH-1:0] rdata,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [D_WIDTH-1:0] m_data,
  output logic               rempty,
  output logic [A_WIDTH:0]   rlevel,
  output logic               rerr
);
  localparam int PW = A_WIDTH + 1;
  logic [A_WIDTH:0] wq_gray, wq_bin, rbin, rbin_next, rgray_next, level_next;
  logic [D_WIDTH-1:0] s0, s1, s0_next, s1_next;
  logic [1:0] skid_cnt, cnt_pop, cnt_next;
  logic inflight, pop;
  sync_ff #(.W(PW), .STAGES(SYNC_STAGES)) u_sync (
    .rclk(rclk), .rrst_n(rrst_n), .d(wptr_gray), .q(wq_gray)
  );
  // Reserve a skid slot for every word already requested; a pop frees one this cycle.
  always_comb begin
    pop = m_valid && m_ready;
    ren = !rempty && (((skid_cnt + 2'(inflight)) < 2'(SKID_DEPTH)) || pop);
    wq_bin = PW'(gray2bin(ptr_t'(wq_gray)));
    rbin_next = rbin + {{A_WIDTH{1'b0}}, ren};
    rgray_next = PW'(bin2gray(ptr_t'(rbin_next)));
    level_next = wq_bin - rbin_next;
    cnt_pop = skid_cnt - {1'b0, pop};
    cnt_next = cnt_pop + {1'b0, inflight};
    s0_next = (inflight && cnt_pop == 2'd0) ? rdata : pop ? s1 : s0;
    s1_next = (inflight && cnt_pop == 2'd1) ? rdata : s1;
  end
  always_ff @(posedge rclk or negedge rrst_n)
    if (!rrst_n) begin
      rbin <= '0;
      rptr_gray <= '0;
      rempty <= 1'b1;
      rlevel <= '0;
      inflight <= 1'b0;
      skid_cnt <= '0;
      s0 <= '0;
      s1 <= '0;
    end else begin
      rbin <= rbin_next;
      rptr_gray <= rgray_next;
      rempty <= rgray_next == wq_gray;
      rlevel <= level_next;
      inflight <= ren;
      skid_cnt <= cnt_next;
      s0 <= s0_next;
      s1 <= s1_next;
    end
  assign raddr = rbin[A_WIDTH-1:0];
  assign m_valid = skid_cnt != 2'd0;
  assign m_data = s0;
`ifdef FIFO_RD_GRAY_CHECK_EN
  logic [A_WIDTH:0] wq_prev;
  always_ff @(posedge rclk or negedge rrst_n)
    if (!rrst_n) begin
      wq_prev <= '0;
      rerr <= 1'b0;
    end else begin
      wq_prev <= wq_gray;
      rerr <= rerr || ($countones(wq_gray ^ wq_prev) > 1) || (level_next > {1'b1, {A_WIDTH{1'b0}}});
    end
`else
  assign rerr = 1'b0;
`endif
endmodule
